reg_file_bank: RTL and testbench



---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_word.sv | 31 +++
 rtl/reg_file_bank.sv | 93 +++++++++
 tb/tb_reg_file_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the register bank: default geometry, word type,
// zero constant and the address-width helper used to size the ports.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  localparam word_t ZERO_WORD = '0;

  // Address bits needed to reach every word; at least one bit even for tiny banks.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_word.sv
// One WIDTH-bit storage word. Each bit is an enable mux feeding a D flip-flop,
// so a disabled word simply recirculates its own value.
module reg_word #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic storedBit_d;
    logic storedBit_q;

    assign storedBit_d = enable ? d[b] : storedBit_q;

    // Per-bit flop; reset clears it immediately regardless of the clock.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        storedBit_q <= 1'b0;
      end else begin
        storedBit_q <= storedBit_d;
      end
    end

    assign q[b] = storedBit_q;
  end

endmodule

// File: rtl/reg_file_bank.sv
// DEPTH x WIDTH register bank with one synchronous write port and two
// combinational read ports. The top word can be hardwired to zero, and an
// optional bypass forwards the write data to a matching read port.
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = addr_width(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2
);

  // Words below this index have real storage; the zero word (if any) does not.
  localparam int STORED = ZERO_REG ? DEPTH - 1 : DEPTH;

  logic [WIDTH-1:0] wordQ [DEPTH];
  logic [DEPTH-1:0] writeEn;
  logic [DEPTH-1:0] readSel1;
  logic [DEPTH-1:0] readSel2;
  logic [WIDTH-1:0] readMux1;
  logic [WIDTH-1:0] readMux2;

  // One-hot write decode and read selects; out-of-range and zero-word
  // addresses enable nothing, and reset suppresses writes (and the bypass).
  always_comb begin
    writeEn  = '0;
    readSel1 = '0;
    readSel2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      writeEn[i]  = RegWrite && !reset && (WriteRegister == ADDR_W'(i)) && (i < STORED);
      readSel1[i] = (ReadRegister1 == ADDR_W'(i));
      readSel2[i] = (ReadRegister2 == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    if (g < STORED) begin : g_reg
      reg_word #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk    (clk),
        .reset  (reset),
        .enable (writeEn[g]),
        .d      (WriteData),
        .q      (wordQ[g])
      );
    end else begin : g_zero
      assign wordQ[g] = '0;
    end
  end

  // Read port 1 mux: unmatched addresses read zero; a live write to the same
  // stored word is forwarded when the bypass is built in.
  always_comb begin
    readMux1 = WIDTH'(ZERO_WORD);
    for (int i = 0; i < DEPTH; i++) begin
      if (readSel1[i]) begin
        readMux1 = wordQ[i];
      end
    end
    if (BYPASS && |(writeEn & readSel1)) begin
      readMux1 = WriteData;
    end
  end

  // Read port 2 mux, identical in behaviour to port 1.
  always_comb begin
    readMux2 = WIDTH'(ZERO_WORD);
    for (int i = 0; i < DEPTH; i++) begin
      if (readSel2[i]) begin
        readMux2 = wordQ[i];
      end
    end
    if (BYPASS && |(writeEn & readSel2)) begin
      readMux2 = WriteData;
    end
  end

  assign ReadData1 = readMux1;
  assign ReadData2 = readMux2;

endmodule

// File: tb/tb_reg_file_bank.sv
// Testbench for reg_file_bank: a default 32x64 bank, the same bank with the
// bypass enabled (both sharing stimulus), and a small 6x8 bank without a zero
// word. Expected values are queued as stimulus is driven and drained against
// the read ports once they have settled.
`timescale 1ns/1ps
module tb_reg_file_bank;

  logic clk = 1'b0;
  logic reset;

  // Shared stimulus for the two 32x64 instances
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [63:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [63:0] aRd1, aRd2, bRd1, bRd2;

  // Stimulus for the small 6x8 instance
  logic       cWe;
  logic [2:0] cWa;
  logic [7:0] cWd;
  logic [2:0] cR1;
  logic [2:0] cR2;
  logic [7:0] cRd1, cRd2;

  typedef enum {SRC_A1, SRC_A2, SRC_B1, SRC_B2, SRC_C1, SRC_C2} src_e;

  typedef struct {
    string       tag;
    src_e        src;
    logic [63:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  reg_file_bank dutA (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (regWrite),
    .WriteRegister (writeReg),
    .WriteData     (writeData),
    .ReadRegister1 (readReg1),
    .ReadRegister2 (readReg2),
    .ReadData1     (aRd1),
    .ReadData2     (aRd2)
  );

  reg_file_bank #(
    .BYPASS (1'b1)
  ) dutB (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (regWrite),
    .WriteRegister (writeReg),
    .WriteData     (writeData),
    .ReadRegister1 (readReg1),
    .ReadRegister2 (readReg2),
    .ReadData1     (bRd1),
    .ReadData2     (bRd2)
  );

  reg_file_bank #(
    .WIDTH    (8),
    .DEPTH    (6),
    .ZERO_REG (1'b0)
  ) dutC (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (cWe),
    .WriteRegister (cWa),
    .WriteData     (cWd),
    .ReadRegister1 (cR1),
    .ReadRegister2 (cR2),
    .ReadData1     (cRd1),
    .ReadData2     (cRd2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic expectResult(input string tag, input src_e src, input logic [63:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drainScoreboard();
    sb_entry_t e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.src)
        SRC_A1:  obs = aRd1;
        SRC_A2:  obs = aRd2;
        SRC_B1:  obs = bRd1;
        SRC_B2:  obs = bRd2;
        SRC_C1:  obs = {56'd0, cRd1};
        SRC_C2:  obs = {56'd0, cRd2};
        default: obs = 'x;
      endcase
      checkOutput(e.tag, obs, e.exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                               input logic [4:0] r1, input logic [4:0] r2);
    regWrite  = we;
    writeReg  = wa;
    writeData = wd;
    readReg1  = r1;
    readReg2  = r2;
  endtask

  task automatic applySmall(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                            input logic [2:0] r1, input logic [2:0] r2);
    cWe = we;
    cWa = wa;
    cWd = wd;
    cR1 = r1;
    cR2 = r2;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd0, 5'd1);
    applySmall(1'b0, 3'd0, 8'h0, 3'd0, 3'd1);
    #2;
    expectResult("resetA1", SRC_A1, 64'h0);
    expectResult("resetA2", SRC_A2, 64'h0);
    expectResult("resetC1", SRC_C1, 64'h0);
    drainScoreboard();

    // Write 0xDEAD to word 3, then clear it with a mid-cycle reset pulse
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 5'd3, 64'hDEAD, 5'd3, 5'd3);
    expectResult("word3BeforeWrite", SRC_A1, 64'h0);
    #2 drainScoreboard();

    @(negedge clk);
    applyStimulus(1'b0, 5'd3, 64'h0, 5'd3, 5'd0);
    expectResult("word3Written", SRC_A1, 64'hDEAD);
    #2 drainScoreboard();

    reset = 1'b1;
    #1;
    expectResult("asyncResetA", SRC_A1, 64'h0);
    expectResult("asyncResetB", SRC_B1, 64'h0);
    drainScoreboard();

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 64'hFFFF, 5'(i), 5'(31 - i));
      expectResult($sformatf("resetSweepA%0d", i), SRC_A1, 64'h0);
      expectResult($sformatf("resetSweepB%0d", i), SRC_B1, 64'h0);
      #1 drainScoreboard();
    end

    // Basic write then read on both ports
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 5'd5, 64'h0123456789ABCDEF, 5'd0, 5'd0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd6, 64'hFFFF_0000, 5'd0, 5'd0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd5, 5'd6);
    expectResult("readWord5", SRC_A1, 64'h0123456789ABCDEF);
    expectResult("readWord6", SRC_A2, 64'h00000000FFFF0000);
    expectResult("readWord5Byp", SRC_B1, 64'h0123456789ABCDEF);
    expectResult("readWord6Byp", SRC_B2, 64'h00000000FFFF0000);
    #2 drainScoreboard();

    // Enable low for three cycles with a tempting address/data
    @(negedge clk);
    applyStimulus(1'b0, 5'd5, 64'h0, 5'd5, 5'd5);
    repeat (3) @(negedge clk);
    expectResult("holdWord5", SRC_A1, 64'h0123456789ABCDEF);
    expectResult("holdWord5Byp", SRC_B2, 64'h0123456789ABCDEF);
    #2 drainScoreboard();

    // Zero word ignores writes and is never bypassed
    @(negedge clk);
    applyStimulus(1'b1, 5'd31, 64'h1234, 5'd31, 5'd31);
    expectResult("zeroRegSameCycle", SRC_A1, 64'h0);
    expectResult("zeroRegBypass", SRC_B1, 64'h0);
    #2 drainScoreboard();
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd31, 5'd31);
    expectResult("zeroRegAfter", SRC_A1, 64'h0);
    expectResult("zeroRegAfterByp", SRC_B2, 64'h0);
    #2 drainScoreboard();

    // Read during write: old data without bypass, new data with it
    @(negedge clk);
    applyStimulus(1'b1, 5'd7, 64'hAA, 5'd0, 5'd0);
    @(negedge clk);
    applyStimulus(1'b1, 5'd7, 64'hBB, 5'd7, 5'd7);
    expectResult("rdwOldPort1", SRC_A1, 64'hAA);
    expectResult("rdwOldPort2", SRC_A2, 64'hAA);
    expectResult("rdwBypPort1", SRC_B1, 64'hBB);
    expectResult("rdwBypPort2", SRC_B2, 64'hBB);
    #2 drainScoreboard();
    @(negedge clk);
    applyStimulus(1'b1, 5'd9, 64'h99, 5'd9, 5'd7);
    expectResult("rdwNewA", SRC_A2, 64'hBB);
    expectResult("rdwNewB", SRC_B2, 64'hBB);
    expectResult("word9OldA", SRC_A1, 64'h0);
    expectResult("word9BypB", SRC_B1, 64'h99);
    #2 drainScoreboard();
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd9, 5'd3);
    expectResult("word9StoredA", SRC_A1, 64'h99);
    expectResult("word3StillClear", SRC_A2, 64'h0);
    #2 drainScoreboard();

    // Small bank: valid write, out-of-range write, then sweep every address
    @(negedge clk);
    applySmall(1'b1, 3'd5, 8'h5A, 3'd5, 3'd0);
    expectResult("smallNoBypass", SRC_C1, 64'h0);
    #2 drainScoreboard();
    @(negedge clk);
    applySmall(1'b1, 3'd7, 8'h77, 3'd7, 3'd7);
    expectResult("smallOutOfRange", SRC_C1, 64'h0);
    #2 drainScoreboard();
    @(negedge clk);
    applySmall(1'b0, 3'd0, 8'h0, 3'd5, 3'd7);
    expectResult("smallWord5", SRC_C1, 64'h5A);
    expectResult("smallAddr7", SRC_C2, 64'h0);
    #2 drainScoreboard();
    for (int i = 0; i < 8; i++) begin
      applySmall(1'b0, 3'd5, 8'hFF, 3'(i), 3'(7 - i));
      expectResult($sformatf("smallSweep%0d", i), SRC_C1, (i == 5) ? 64'h5A : 64'h0);
      expectResult($sformatf("smallSweepRev%0d", i), SRC_C2, (i == 2) ? 64'h5A : 64'h0);
      #1 drainScoreboard();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
